// File: rtl/uart_tx_stream_if.sv
// uart_tx_stream_if: valid/ready word stream feeding uart_tx_stream
interface uart_tx_stream_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-buffered UART transmitter with running CRC-8 and on-demand CRC trailer frame.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit after the data bits.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    uart_tx_stream_if.slave             stream,
    input  logic                        hold,
    input  logic                        send_crc,
    input  logic                        clear_crc,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_odd,
`endif
    output logic                        data_out,
    output logic                        busy,
    output logic [7:0]                  crc8,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic r_par;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               r_state, w_next;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [AW:0]          r_cnt;
    logic [DATA_BITS-1:0] r_word, w_word;
    logic [CW-1:0]        r_clk;
    logic [3:0]           r_bit;
    logic [7:0]           r_crc, r_hold;
    logic                 r_pend;
    logic                 w_tick, w_push, w_pop, w_launch, w_crc_launch;

    function automatic logic [7:0] crc_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign stream.in_ready = (r_cnt != (AW+1)'(FIFO_DEPTH)) && !r_pend;
    assign w_push       = stream.in_valid && stream.in_ready;
    assign w_launch     = (r_state == IDLE) && !hold && ((r_cnt != '0) || r_pend);
    assign w_pop        = w_launch && (r_cnt != '0);
    assign w_crc_launch = w_launch && (r_cnt == '0);
    assign w_word       = w_pop ? r_mem[r_rp] : DATA_BITS'(r_hold);
    assign w_tick       = r_clk == CW'(CLKS_PER_BIT - 1);
    assign busy         = (r_state != IDLE) || (r_cnt != '0) || r_pend;
    assign crc8         = r_crc;
    assign fifo_count   = r_cnt;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wp] <= stream.in_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_crc   <= '0;
            r_hold  <= '0;
            r_pend  <= 1'b0;
            r_clk   <= '0;
            r_bit   <= '0;
            r_word  <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // starting the trailer frame restarts the CRC; no word can be accepted that cycle
            r_crc   <= w_crc_launch ? 8'h00 :
                       w_push ? crc_next(clear_crc ? 8'h00 : r_crc, stream.in_data[7:0]) :
                       clear_crc ? 8'h00 : r_crc;
            r_pend  <= w_crc_launch ? 1'b0 : (send_crc ? 1'b1 : r_pend);
            r_hold  <= (send_crc && !r_pend) ? r_crc : r_hold;
            r_clk   <= (r_state == IDLE || w_tick) ? '0 : r_clk + CW'(1);
            r_bit   <= (w_next != r_state) ? '0 : r_bit + 4'(w_tick);
            r_word  <= w_launch ? w_word : (r_state == DATA && w_tick) ? r_word >> 1 : r_word;
`ifdef UART_TX_PARITY_EN
            if (w_launch) r_par <= ^w_word ^ parity_odd;
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   w_next = w_launch ? START : IDLE;
            START:  w_next = w_tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   w_next = (w_tick && r_bit == 4'(DATA_BITS - 1)) ? PARITY : DATA;
            PARITY: w_next = w_tick ? STOP : PARITY;
`else
            DATA:   w_next = (w_tick && r_bit == 4'(DATA_BITS - 1)) ? STOP : DATA;
`endif
            STOP:   w_next = (w_tick && r_bit == 4'(STOP_BITS - 1)) ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        data_out = 1'b1;
        case (r_state)
            START:  data_out = 1'b0;
            DATA:   data_out = r_word[0];
`ifdef UART_TX_PARITY_EN
            PARITY: data_out = r_par;
`endif
            default: data_out = 1'b1;
        endcase
    end
endmodule
